// File: rtl/bsg_enable_sequencer.sv
// rtl/bsg_enable_sequencer.sv - staggered per-channel enable release after reset
// Optional restart_i input is enabled by defining BSG_ENABLE_SEQ_RESTART_EN.
module bsg_enable_sequencer #(
    parameter int width_p = 16,
    parameter int delay_p = 8,
    parameter int gap_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
`ifdef BSG_ENABLE_SEQ_RESTART_EN
    input  logic               restart_i,
`endif
    input  logic [width_p-1:0] req_i,
    output logic [width_p-1:0] en_o,
    output logic               done_o
);

    localparam int MAX_LP  = (delay_p > gap_p) ? delay_p : gap_p;
    localparam int TIMER_W = $clog2(MAX_LP + 1);
    localparam int IDX_W   = $clog2(width_p + 1);

    typedef enum logic [1:0] {
        S_DELAY,
        S_STEP,
        S_GAP,
        S_DONE
    } state_t;

    state_t               r_state, w_state;
    logic [TIMER_W-1:0]   r_timer, w_timer;
    logic [IDX_W-1:0]     r_index, w_index;
    logic [width_p-1:0]   r_en, w_en;
    logic                 r_done, w_done;

    logic                 w_restart;
    logic                 w_eval;
    logic                 w_last;
    logic                 w_req_cur;
    logic [width_p-1:0]   w_onehot;

`ifdef BSG_ENABLE_SEQ_RESTART_EN
    assign w_restart = restart_i;
`else
    assign w_restart = 1'b0;
`endif

    // Onehot shifts to zero once the index saturates at width_p.
    assign w_onehot  = width_p'(1) << r_index;
    assign w_req_cur = |(req_i & w_onehot);
    assign w_last    = (r_index == IDX_W'(width_p - 1));

    always_comb begin
        w_state = r_state;
        w_timer = r_timer;
        w_index = r_index;
        w_en    = r_en & req_i;
        w_done  = r_done;
        w_eval  = 1'b0;

        unique case (r_state)
            S_DELAY: begin
                if (r_timer == '0) w_eval = 1'b1;
                else               w_timer = r_timer - TIMER_W'(1);
            end
            S_STEP: w_eval = 1'b1;
            S_GAP: begin
                // Timer was loaded with gap_p, so the evaluation lands gap_p edges after the enable.
                if (r_timer <= TIMER_W'(1)) w_eval = 1'b1;
                else                        w_timer = r_timer - TIMER_W'(1);
            end
            S_DONE: ;
            default: w_state = S_DELAY;
        endcase

        if (w_eval) begin
            if (w_req_cur) w_en = w_en | w_onehot;
            if (w_last) begin
                w_state = S_DONE;
                w_done  = 1'b1;
                w_index = IDX_W'(width_p);
            end else begin
                w_index = r_index + IDX_W'(1);
                if (w_req_cur) begin
                    w_timer = TIMER_W'(gap_p);
                    w_state = S_GAP;
                end else begin
                    w_state = S_STEP;
                end
            end
        end

        if (w_restart) begin
            w_state = S_DELAY;
            w_timer = TIMER_W'(delay_p);
            w_index = '0;
            w_en    = '0;
            w_done  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_DELAY;
            r_timer <= TIMER_W'(delay_p);
            r_index <= '0;
            r_en    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_timer <= w_timer;
            r_index <= w_index;
            r_en    <= w_en;
            r_done  <= w_done;
        end
    end

    assign en_o   = r_en;
    assign done_o = r_done;

endmodule
